// File: rtl/fft_mem_pkg.sv
// rtl/fft_mem_pkg.sv - shared FSM state type and address-width helper for the coefficient memory
package fft_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

    // A single-word table still needs a one-bit address port.
    function automatic int calc_addrw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/coef_ram_1w1r.sv
// rtl/coef_ram_1w1r.sv - DEPTH x WIDTH array, synchronous write, combinational read
module coef_ram_1w1r
    import fft_mem_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    localparam int ADDRW = calc_addrw(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ADDRW-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [ADDRW-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Addresses beyond the table read as zero so non-power-of-two depths are safe.
    assign rdata = (32'(raddr) < DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/coef_ram_loader.sv
// rtl/coef_ram_loader.sv - stream loader for the coefficient RAM; COEF_CHECKSUM_EN adds a load checksum
module coef_ram_loader
    import fft_mem_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    localparam int ADDRW = calc_addrw(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    output logic             s_ready,
    output logic             busy,
    output logic             done,
    output logic [ADDRW:0]   load_count,
    input  logic [ADDRW-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data
`ifdef COEF_CHECKSUM_EN
    ,
    output logic [WIDTH-1:0] checksum
`endif
);

    localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(DEPTH - 1);

    state_e           state_q, state_d;
    logic [ADDRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRW:0]   load_count_q, load_count_d;
    logic             we;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        load_count_d = load_count_q;
        we           = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d      = LOAD;
                    wr_ptr_d     = '0;
                    load_count_d = '0;
                end
            end
            LOAD: begin
                // start is deliberately ignored here; only handshakes advance the load.
                if (s_valid) begin
                    we           = 1'b1;
                    load_count_d = load_count_q + 1'b1;
                    if (wr_ptr_q == LAST_ADDR) begin
                        wr_ptr_d = '0;
                        state_d  = DONE;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            load_count_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            load_count_q <= load_count_d;
        end
    end

`ifdef COEF_CHECKSUM_EN
    logic [WIDTH-1:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if ((state_q != LOAD) && start) begin
            checksum_d = '0;
        end else if (we) begin
            checksum_d = checksum_q + s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`endif

    // Handshake and status are pure state decodes so s_ready never depends on s_valid.
    assign s_ready    = (state_q == LOAD);
    assign busy       = (state_q == LOAD);
    assign done       = (state_q == DONE);
    assign load_count = load_count_q;

    coef_ram_1w1r #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr_q),
        .wdata (s_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule
